cell_scan_controller: RTL
=========================

Name: cell_scan_controller

Overview:
- Sequencer that walks a stored image raster-order and feeds each pixel's 3x3 neighbourhood to the cell processor.
- Fetches neighbourhoods from a dual-bank pixel memory: bank A feeds cellA, bank B feeds cellB.
- Holds the opcode and user operand stable for the whole frame.
- Writes each processed centre pixel to the output frame buffer under a ready handshake.

Parameters:
- PIXEL_W, 8, bits per pixel.
- IMG_W, 64, image width in pixels (>=2).
- IMG_H, 64, image height in pixels (>=2).
- ADDR_W, $clog2(IMG_W*IMG_H), pixel address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle frame request; sampled in IDLE only.
- op_in  in  opcode_t  operation for the frame.
- user_in  in  PIXEL_W  immediate for ADDI/SUBI.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse after the last write completes.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  read address, = y*IMG_W+x.
- rd_data_a  in  PIXEL_W  bank A data, valid 1 cycle after rd_en.
- rd_data_b  in  PIXEL_W  bank B data, valid 1 cycle after rd_en.
- cell_a  out  9*PIXEL_W  to processor cellA; index 4 = centre, row-major.
- cell_b  out  9*PIXEL_W  to processor cellB.
- opcode  out  opcode_t  to processor, latched op_in.
- user_a  out  PIXEL_W  to processor userInputA, latched user_in.
- proc_result  in  PIXEL_W  processor processedCell, combinational.
- wr_en  out  1  write request; held until accepted.
- wr_ready  in  1  sink accepts the write when wr_en && wr_ready.
- wr_addr  out  ADDR_W  output address, = centre pixel address.
- wr_data  out  PIXEL_W  registered result.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy, done, rd_en, wr_en = 0.
  - rd_addr, wr_addr, wr_data, cell_a, cell_b, user_a = 0; opcode = ADD.
  - Reset mid-frame aborts with no done pulse.
- IDLE:
  - On start=1: latch op_in and user_in, set x=y=0, go to FETCH.
  - busy rises the next cycle.
- FETCH (9 cycles):
  - Issues rd_en with neighbour offsets (dy,dx) from (-1,-1) to (+1,+1), row-major, k=0..8.
  - Coordinates are clamped to [0,IMG_W-1] x [0,IMG_H-1] (edge replication).
  - Data for read k is captured into slot k of cell_a/cell_b one cycle later.
- DRAIN (1 cycle): captures slot 8; rd_en=0.
- EXEC (1 cycle):
  - cell_a, cell_b, opcode and user_a are stable.
  - Registers proc_result into wr_data; wr_addr = y*IMG_W+x.
- WRITE:
  - wr_en=1, held with wr_addr and wr_data unchanged until wr_ready=1.
  - After acceptance: advance x; wrap x to 0 and increment y at IMG_W-1.
  - Last pixel (IMG_W-1,IMG_H-1): go to DONE; otherwise go to FETCH.
- DONE: done=1 for one cycle, busy=0 the same cycle, then IDLE.
- Cadence: 12 cycles per pixel with wr_ready tied high. Frame latency = 12*IMG_W*IMG_H + 2 cycles from start to done.
- start while busy is ignored; op_in and user_in changes mid-frame are ignored.
- cell_a and cell_b hold their values between pixels; slots are overwritten in order.

Optional Feature:
- Macro CELL_SCAN_ZERO_PAD_EN.
- Defined: out-of-image neighbours are replaced with 0 in both cells. rd_en is still issued at the clamped address, so timing is unchanged.
- Undefined: edge replication via clamped addresses.

Decomposition:
- Shared package CellProcessingPkg:
  - existing opcode_t, pixel_t, cell_t, centerPixel;
  - new scan_state_t {IDLE, FETCH, DRAIN, EXEC, WRITE, DONE};
  - new CELL_PIXELS=9 constant.
- One sub-module, cell_addr_gen: converts (x,y,k) to the clamped address plus an out-of-bounds flag.
- The FSM and counters live in cell_scan_controller.

Test Plan:
- IMG_W=IMG_H=4, bank A[i]=i, op ADD, bank B all 1, wr_ready=1:
  - pixel (1,1) writes wr_addr=5 with the processor result for centre 5 plus B;
  - done asserts exactly 194 cycles after start.
- Same image, op AVG, corner (0,0):
  - rd_addr sequence is 0,0,1,0,0,1,4,4,5;
  - cell_a slot 4 = 0.
- With CELL_SCAN_ZERO_PAD_EN: corner (0,0) cell_a slots 0,1,2,3,6 = 0; slots 4,5,7,8 = 0,1,4,5.
- wr_ready held low 5 cycles at pixel 3:
  - wr_en, wr_addr=3 and wr_data are stable throughout;
  - no rd_en during the stall;
  - the frame resumes afterwards.
- start pulsed while busy, with op_in changed to SUB: ignored; opcode output stays ADD; exactly one done pulse.
- rst asserted during FETCH of pixel 7:
  - all outputs go to 0 immediately, no done pulse;
  - a new start re-runs from pixel 0.

Source files
------------

// File: rtl/cell_scan_controller_pkg.sv
// Shared types for the cell scan controller and the cell processor:
// opcodes, pixel/cell types, scan FSM states and neighbour-offset helpers.
package CellProcessingPkg;

  localparam int PKG_PIXEL_W = 8;
  localparam int CELL_PIXELS = 9;

  typedef enum logic [2:0] {ADD, SUB, ADDI, SUBI, AVG, MAX, MIN, PASS} opcode_t;

  typedef logic [PKG_PIXEL_W-1:0] pixel_t;
  typedef pixel_t [CELL_PIXELS-1:0] cell_t;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EXEC, WRITE, DONE} scan_state_t;

  function automatic pixel_t centerPixel(input cell_t c);
    return c[4];
  endfunction

  // Slot k of a 3x3 window, row-major, maps to offsets (dy,dx) in {-1,0,+1}.
  function automatic int nbr_dx(input logic [3:0] k);
    return int'(k % 4'd3) - 1;
  endfunction

  function automatic int nbr_dy(input logic [3:0] k);
    return int'(k / 4'd3) - 1;
  endfunction

endpackage

// File: rtl/cell_scan_controller_if.sv
// Memory, processor and output-sink signals of the cell scan controller.
// master = controller side, slave = memory/processor/frame-buffer side.
interface cell_scan_controller_if
  import CellProcessingPkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int ADDR_W  = 12
);
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [PIXEL_W-1:0]     rd_data_a;
  logic [PIXEL_W-1:0]     rd_data_b;
  logic [9*PIXEL_W-1:0]   cell_a;
  logic [9*PIXEL_W-1:0]   cell_b;
  opcode_t                opcode;
  logic [PIXEL_W-1:0]     user_a;
  logic [PIXEL_W-1:0]     proc_result;
  logic                   wr_en;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [PIXEL_W-1:0]     wr_data;

  modport master (
    output rd_en, rd_addr, cell_a, cell_b, opcode, user_a, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, proc_result, wr_ready
  );

  modport slave (
    input  rd_en, rd_addr, cell_a, cell_b, opcode, user_a, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, proc_result, wr_ready
  );
endinterface

// File: rtl/cell_scan_controller_addr_gen.sv
// cell_addr_gen: maps centre (x,y) and window slot k to a clamped pixel
// address, flagging neighbours that fall outside the image.
module cell_addr_gen
  import CellProcessingPkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H),
  parameter int XW     = $clog2(IMG_W),
  parameter int YW     = $clog2(IMG_H)
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  int nx, ny, cx, cy;

  always_comb begin
    nx  = int'(x) + nbr_dx(k);
    ny  = int'(y) + nbr_dy(k);
    oob = (nx < 0) || (nx > IMG_W-1) || (ny < 0) || (ny > IMG_H-1);
    cx  = (nx < 0) ? 0 : ((nx > IMG_W-1) ? IMG_W-1 : nx);
    cy  = (ny < 0) ? 0 : ((ny > IMG_H-1) ? IMG_H-1 : ny);
    addr = ADDR_W'(cy * IMG_W + cx);
  end

endmodule

// File: rtl/cell_scan_controller.sv
// Raster-order scan sequencer: fetches each pixel's 3x3 window from two memory
// banks, hands it to the cell processor and writes the result out.
// Optional build macro CELL_SCAN_ZERO_PAD_EN: out-of-image neighbours read as 0.
module cell_scan_controller
  import CellProcessingPkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int ADDR_W  = $clog2(IMG_W*IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  opcode_t             op_in,
  input  logic [PIXEL_W-1:0]  user_in,
  output logic                busy,
  output logic                done,
  cell_scan_controller_if.master bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

`ifdef CELL_SCAN_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  scan_state_t         state_reg, state_next;
  logic [XW-1:0]       x_reg;
  logic [YW-1:0]       y_reg;
  logic [3:0]          k_reg;
  logic                busy_reg, done_reg;
  opcode_t             opcode_reg;
  logic [PIXEL_W-1:0]  user_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [PIXEL_W-1:0]  wr_data_reg;
  logic                cap_valid_reg;
  logic [3:0]          cap_slot_reg;
  logic                cap_oob_reg;

  logic                rd_en_c, wr_en_c, oob_c, last_pixel, pad_hit;
  logic [ADDR_W-1:0]   rd_addr_c;

  cell_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .XW     (XW),
    .YW     (YW)
  ) u_addr_gen (
    .x    (x_reg),
    .y    (y_reg),
    .k    (k_reg),
    .addr (rd_addr_c),
    .oob  (oob_c)
  );

  assign last_pixel = (x_reg == XW'(IMG_W-1)) && (y_reg == YW'(IMG_H-1));
  assign pad_hit    = ZERO_PAD && cap_oob_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rd_en_c    = 1'b0;
    wr_en_c    = 1'b0;
    unique case (state_reg)
      IDLE:  if (start) state_next = FETCH;
      FETCH: begin
        rd_en_c = 1'b1;
        if (k_reg == 4'd8) state_next = DRAIN;
      end
      DRAIN: state_next = EXEC;
      EXEC:  state_next = WRITE;
      WRITE: begin
        wr_en_c = 1'b1;
        if (bus.wr_ready) state_next = last_pixel ? DONE : FETCH;
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg         <= '0;
      y_reg         <= '0;
      k_reg         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      opcode_reg    <= ADD;
      user_reg      <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      cap_valid_reg <= 1'b0;
      cap_slot_reg  <= '0;
      cap_oob_reg   <= 1'b0;
    end else begin
      done_reg      <= (state_reg == DONE);
      // Read data returns one cycle after the strobe, so its slot tag trails k.
      cap_valid_reg <= rd_en_c;
      cap_slot_reg  <= k_reg;
      cap_oob_reg   <= oob_c;
      case (state_reg)
        IDLE: if (start) begin
          opcode_reg <= op_in;
          user_reg   <= user_in;
          x_reg      <= '0;
          y_reg      <= '0;
          k_reg      <= '0;
          busy_reg   <= 1'b1;
        end
        FETCH: k_reg <= (k_reg == 4'd8) ? 4'd0 : k_reg + 4'd1;
        EXEC: begin
          wr_data_reg <= bus.proc_result;
          wr_addr_reg <= ADDR_W'(int'(y_reg) * IMG_W + int'(x_reg));
        end
        WRITE: if (bus.wr_ready) begin
          if (x_reg == XW'(IMG_W-1)) begin
            x_reg <= '0;
            y_reg <= (y_reg == YW'(IMG_H-1)) ? '0 : y_reg + YW'(1);
          end else begin
            x_reg <= x_reg + XW'(1);
          end
        end
        DONE: busy_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CELL_PIXELS; gi++) begin : g_slot
      logic [PIXEL_W-1:0] slot_a_reg, slot_b_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_a_reg <= '0;
          slot_b_reg <= '0;
        end else if (cap_valid_reg && cap_slot_reg == 4'(gi)) begin
          slot_a_reg <= pad_hit ? '0 : bus.rd_data_a;
          slot_b_reg <= pad_hit ? '0 : bus.rd_data_b;
        end
      end

      assign bus.cell_a[gi*PIXEL_W +: PIXEL_W] = slot_a_reg;
      assign bus.cell_b[gi*PIXEL_W +: PIXEL_W] = slot_b_reg;
    end
  endgenerate

  assign bus.rd_en   = rd_en_c;
  assign bus.rd_addr = rd_addr_c;
  assign bus.wr_en   = wr_en_c;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign bus.opcode  = opcode_reg;
  assign bus.user_a  = user_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule
